// File: rtl/id_operand_read_if.sv
// Bus between decode and the operand-read stage: writeback port, decode bundle,
// EX/MEM forwarding taps and the registered ID/EX bundle.
interface id_operand_read_if;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_raddr1;
    logic [4:0]  id_raddr2;
    logic        id_ren1;
    logic        id_ren2;
    logic        id_we;
    logic [4:0]  id_waddr;
    logic        id_is_load;

    logic        ex_fwd_we;
    logic        ex_fwd_is_load;
    logic [4:0]  ex_fwd_waddr;
    logic [31:0] ex_fwd_wdata;
    logic        mem_fwd_we;
    logic [4:0]  mem_fwd_waddr;
    logic [31:0] mem_fwd_wdata;

    logic        es_allowin;
    logic        id_ready;
    logic        es_valid;
    logic [31:0] es_pc;
    logic [31:0] es_src1;
    logic [31:0] es_src2;
    logic        es_we;
    logic [4:0]  es_waddr;
    logic        es_is_load;

    modport master (
        output rf_we, rf_waddr, rf_wdata,
        output id_valid, id_pc, id_raddr1, id_raddr2, id_ren1, id_ren2,
        output id_we, id_waddr, id_is_load,
        output ex_fwd_we, ex_fwd_is_load, ex_fwd_waddr, ex_fwd_wdata,
        output mem_fwd_we, mem_fwd_waddr, mem_fwd_wdata,
        output es_allowin,
        input  id_ready, es_valid, es_pc, es_src1, es_src2, es_we, es_waddr, es_is_load
    );

    modport slave (
        input  rf_we, rf_waddr, rf_wdata,
        input  id_valid, id_pc, id_raddr1, id_raddr2, id_ren1, id_ren2,
        input  id_we, id_waddr, id_is_load,
        input  ex_fwd_we, ex_fwd_is_load, ex_fwd_waddr, ex_fwd_wdata,
        input  mem_fwd_we, mem_fwd_waddr, mem_fwd_wdata,
        input  es_allowin,
        output id_ready, es_valid, es_pc, es_src1, es_src2, es_we, es_waddr, es_is_load
    );
endinterface

// File: rtl/id_operand_read.sv
// Decode operand read: 32x32 register file, EX/MEM/WB forwarding, load-use stall
// and the registered ID/EX bundle behind a valid/allowin handshake.
module id_operand_read (
    input  logic              clk,
    input  logic              rst,
    id_operand_read_if.slave  bus
);
    localparam logic [31:0] RESET_PC_BUBBLE = 32'h1bfffffc;

    logic [31:0] rf_reg [32];

    logic [4:0]  raddr     [2];
    logic        ren       [2];
    logic [31:0] src_val   [2];
    logic        load_hit  [2];

    logic        id_live;
    logic        stall;

    logic        es_valid_reg;
    logic [31:0] es_pc_reg;
    logic [31:0] es_src1_reg;
    logic [31:0] es_src2_reg;
    logic        es_we_reg;
    logic [4:0]  es_waddr_reg;
    logic        es_is_load_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf_reg[i] <= 32'd0;
        end else if (bus.rf_we && bus.rf_waddr != 5'd0) begin
            rf_reg[bus.rf_waddr] <= bus.rf_wdata;
        end
    end

    assign raddr[0] = bus.id_raddr1;
    assign raddr[1] = bus.id_raddr2;
    assign ren[0]   = bus.id_ren1;
    assign ren[1]   = bus.id_ren2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            logic [31:0] val;
            logic        hit;
            // A load sitting in EX has no data yet, so its match stops the search here.
            always_comb begin
                val = 32'd0;
                hit = 1'b0;
                if (ren[gi] && raddr[gi] != 5'd0) begin
                    if (bus.ex_fwd_we && bus.ex_fwd_waddr == raddr[gi]) begin
                        val = bus.ex_fwd_wdata;
                        hit = bus.ex_fwd_is_load;
                    end else if (bus.mem_fwd_we && bus.mem_fwd_waddr == raddr[gi]) begin
                        val = bus.mem_fwd_wdata;
                    end else if (bus.rf_we && bus.rf_waddr == raddr[gi]) begin
                        val = bus.rf_wdata;
                    end else begin
                        val = rf_reg[raddr[gi]];
                    end
                end
            end
            assign src_val[gi]  = val;
            assign load_hit[gi] = hit;
        end
    endgenerate

    // The fetch bubble left behind by reset carries this PC and must not issue.
    assign id_live = bus.id_valid && (bus.id_pc != RESET_PC_BUBBLE);
    assign stall   = id_live && (load_hit[0] || load_hit[1]);
    assign bus.id_ready = bus.es_allowin && !stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            es_valid_reg   <= 1'b0;
            es_pc_reg      <= 32'd0;
            es_src1_reg    <= 32'd0;
            es_src2_reg    <= 32'd0;
            es_we_reg      <= 1'b0;
            es_waddr_reg   <= 5'd0;
            es_is_load_reg <= 1'b0;
        end else if (bus.es_allowin) begin
            if (stall) begin
                es_valid_reg   <= 1'b0;
                es_pc_reg      <= 32'd0;
                es_src1_reg    <= 32'd0;
                es_src2_reg    <= 32'd0;
                es_we_reg      <= 1'b0;
                es_waddr_reg   <= 5'd0;
                es_is_load_reg <= 1'b0;
            end else begin
                es_valid_reg   <= id_live;
                es_pc_reg      <= bus.id_pc;
                es_src1_reg    <= src_val[0];
                es_src2_reg    <= src_val[1];
                es_we_reg      <= bus.id_we && id_live;
                es_waddr_reg   <= bus.id_waddr;
                es_is_load_reg <= bus.id_is_load;
            end
        end
    end

    assign bus.es_valid   = es_valid_reg;
    assign bus.es_pc      = es_pc_reg;
    assign bus.es_src1    = es_src1_reg;
    assign bus.es_src2    = es_src2_reg;
    assign bus.es_we      = es_we_reg;
    assign bus.es_waddr   = es_waddr_reg;
    assign bus.es_is_load = es_is_load_reg;
endmodule

// File: tb/tb_id_operand_read.sv
// Directed bench for id_operand_read: register file, forwarding priority,
// load-use bubble, back-pressure, reset-bubble sentinel and async reset.
module tb_id_operand_read;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    id_operand_read_if bus ();

    id_operand_read dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", tag, actual, expected);
        end else begin
            $display("ok   %s value=%h", tag, actual);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.rf_we = 0; bus.rf_waddr = 0; bus.rf_wdata = 0;
        bus.id_valid = 0; bus.id_pc = 0; bus.id_raddr1 = 0; bus.id_raddr2 = 0;
        bus.id_ren1 = 0; bus.id_ren2 = 0; bus.id_we = 0; bus.id_waddr = 0; bus.id_is_load = 0;
        bus.ex_fwd_we = 0; bus.ex_fwd_is_load = 0; bus.ex_fwd_waddr = 0; bus.ex_fwd_wdata = 0;
        bus.mem_fwd_we = 0; bus.mem_fwd_waddr = 0; bus.mem_fwd_wdata = 0;
        bus.es_allowin = 1;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] wa);
        bus.id_valid = 1; bus.id_pc = pc;
        bus.id_raddr1 = r1; bus.id_ren1 = 1;
        bus.id_raddr2 = r2; bus.id_ren2 = 1;
        bus.id_we = 1; bus.id_waddr = wa; bus.id_is_load = 0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #4 rst = 0;
        step();
        check("reset_es_valid", {31'd0, bus.es_valid}, 32'd0);
        check("reset_es_src1", bus.es_src1, 32'd0);
        check("reset_es_pc", bus.es_pc, 32'd0);

        // Writeback and read of r5 in the same cycle
        issue(32'h1c000000, 5'd5, 5'd0, 5'd9);
        bus.rf_we = 1; bus.rf_waddr = 5; bus.rf_wdata = 32'hDEADBEEF;
        step();
        check("wb_bypass_src1", bus.es_src1, 32'hDEADBEEF);
        check("wb_bypass_valid", {31'd0, bus.es_valid}, 32'd1);
        check("wb_bypass_we", {31'd0, bus.es_we}, 32'd1);
        check("wb_bypass_waddr", {27'd0, bus.es_waddr}, 32'd9);
        check("wb_bypass_pc", bus.es_pc, 32'h1c000000);

        bus.rf_we = 0;
        issue(32'h1c000004, 5'd0, 5'd5, 5'd1);
        step();
        check("rf_read_r5", bus.es_src2, 32'hDEADBEEF);

        // r0 ignores writes
        issue(32'h1c000008, 5'd0, 5'd0, 5'd1);
        bus.rf_we = 1; bus.rf_waddr = 0; bus.rf_wdata = 32'h1234;
        step();
        check("r0_same_cycle", bus.es_src1, 32'd0);
        bus.rf_we = 0;
        step();
        check("r0_after_write", bus.es_src1, 32'd0);

        // Forwarding priority EX > MEM > WB
        issue(32'h1c00000c, 5'd3, 5'd0, 5'd2);
        bus.ex_fwd_we = 1;  bus.ex_fwd_waddr = 3;  bus.ex_fwd_wdata = 32'h11;
        bus.mem_fwd_we = 1; bus.mem_fwd_waddr = 3; bus.mem_fwd_wdata = 32'h22;
        bus.rf_we = 1;      bus.rf_waddr = 3;      bus.rf_wdata = 32'h33;
        step();
        check("fwd_ex_wins", bus.es_src1, 32'h11);
        bus.ex_fwd_we = 0;
        step();
        check("fwd_mem_wins", bus.es_src1, 32'h22);
        bus.mem_fwd_we = 0;
        step();
        check("fwd_wb_wins", bus.es_src1, 32'h33);
        bus.rf_we = 0;
        bus.ex_fwd_we = 1; bus.ex_fwd_waddr = 3; bus.ex_fwd_wdata = 32'h77;
        bus.id_ren1 = 0;
        step();
        check("ren_off_zero", bus.es_src1, 32'd0);
        bus.ex_fwd_we = 0; bus.id_ren1 = 1;
        step();
        check("rf_read_r3", bus.es_src1, 32'h33);

        // Load-use on src2
        issue(32'h1c000010, 5'd0, 5'd7, 5'd4);
        bus.ex_fwd_we = 1; bus.ex_fwd_is_load = 1; bus.ex_fwd_waddr = 7; bus.ex_fwd_wdata = 32'hBAD;
        #1;
        check("loaduse_ready", {31'd0, bus.id_ready}, 32'd0);
        step();
        check("loaduse_bubble_valid", {31'd0, bus.es_valid}, 32'd0);
        check("loaduse_bubble_we", {31'd0, bus.es_we}, 32'd0);
        bus.ex_fwd_we = 0; bus.ex_fwd_is_load = 0;
        bus.mem_fwd_we = 1; bus.mem_fwd_waddr = 7; bus.mem_fwd_wdata = 32'hCAFE;
        #1;
        check("loaduse_ready_after", {31'd0, bus.id_ready}, 32'd1);
        step();
        check("loaduse_mem_fwd", bus.es_src2, 32'hCAFE);
        check("loaduse_valid_after", {31'd0, bus.es_valid}, 32'd1);
        bus.mem_fwd_we = 0;

        // Back-pressure: outputs hold while EX refuses
        issue(32'h00000100, 5'd5, 5'd3, 5'd6);
        step();
        check("bp_capture_pc", bus.es_pc, 32'h00000100);
        bus.es_allowin = 0;
        for (int i = 1; i <= 3; i++) begin
            issue(32'h00000100 + 32'(i * 4), 5'd3, 5'd5, 5'd8);
            #1;
            check($sformatf("bp_ready_%0d", i), {31'd0, bus.id_ready}, 32'd0);
            step();
            check($sformatf("bp_hold_pc_%0d", i), bus.es_pc, 32'h00000100);
            check($sformatf("bp_hold_src1_%0d", i), bus.es_src1, 32'hDEADBEEF);
        end
        bus.es_allowin = 1;
        step();
        check("bp_release_pc", bus.es_pc, 32'h0000010C);
        check("bp_release_src1", bus.es_src1, 32'h33);
        check("bp_release_waddr", {27'd0, bus.es_waddr}, 32'd8);

        // Reset fetch bubble
        issue(32'h1bfffffc, 5'd5, 5'd0, 5'd10);
        #1;
        check("sentinel_ready", {31'd0, bus.id_ready}, 32'd1);
        step();
        check("sentinel_valid", {31'd0, bus.es_valid}, 32'd0);
        check("sentinel_we", {31'd0, bus.es_we}, 32'd0);

        // Async reset asserted mid-cycle while stalled, with a pending write
        issue(32'h1c000020, 5'd5, 5'd0, 5'd11);
        step();
        check("pre_reset_src1", bus.es_src1, 32'hDEADBEEF);
        issue(32'h1c000024, 5'd0, 5'd12, 5'd11);
        bus.ex_fwd_we = 1; bus.ex_fwd_is_load = 1; bus.ex_fwd_waddr = 12;
        bus.rf_we = 1; bus.rf_waddr = 5; bus.rf_wdata = 32'h55AA55AA;
        #3 rst = 1;
        #1;
        check("async_rst_valid", {31'd0, bus.es_valid}, 32'd0);
        check("async_rst_src1", bus.es_src1, 32'd0);
        @(posedge clk);
        #4 rst = 0;
        idle_inputs();
        issue(32'h1c000028, 5'd5, 5'd0, 5'd1);
        step();
        check("post_reset_r5", bus.es_src1, 32'd0);
        check("post_reset_valid", {31'd0, bus.es_valid}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/id_operand_read.md
# id_operand_read

Decode-side operand read stage of the five-stage LoongArch pipeline. Holds the 32×32 general register file, accepts the writeback port driven by the MEM/WB pipeline register, and reads two source operands per decoded instruction. Resolves operands by forwarding from the EX, MEM and WB stages, detects load-use hazards and stalls on them. Registers the resolved bundle into the ID/EX boundary under a valid/allowin handshake.

## Interface
- No parameters; widths fixed: XLEN 32, 32 registers, 5-bit address.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- rf_we  in  1  writeback enable from MEM/WB
- rf_waddr  in  5  writeback register
- rf_wdata  in  32  writeback data
- id_valid  in  1  decode bundle present
- id_pc  in  32  decode PC
- id_raddr1 / id_raddr2  in  5  source registers
- id_ren1 / id_ren2  in  1  source actually used
- id_we  in  1  instruction writes a register
- id_waddr  in  5  destination register
- id_is_load  in  1  instruction is a load
- ex_fwd_we, ex_fwd_is_load  in  1  EX-stage result valid / is a load (gated by EX valid upstream)
- ex_fwd_waddr  in  5;  ex_fwd_wdata  in  32
- mem_fwd_we  in  1;  mem_fwd_waddr  in  5;  mem_fwd_wdata  in  32
- es_allowin  in  1  EX can accept a bundle this cycle
- id_ready  out  1  decode bundle consumed this cycle
- es_valid  out  1  registered bundle valid
- es_pc  out  32;  es_src1 / es_src2  out  32
- es_we  out  1;  es_waddr  out  5;  es_is_load  out  1

## Operation
- Register file: r0 reads 0 always; writes to r0 dropped. Write on posedge when rf_we=1.
- Per-source resolution (only if renN=1 and raddrN≠0; else value 0, no hazard). Priority: EX match (ex_fwd_we, addr equal) > MEM match > WB match (rf_we, rf_waddr equal, same-cycle write-through) > register file.
- Load-use: stall = id_valid & (src1 or src2 matches EX with ex_fwd_is_load=1). EX-load match never falls through to MEM/WB.
- Sentinel: id_pc = 32'h1bfffffc treated as id_valid=0 (reset fetch bubble).
- id_ready = es_allowin & ~stall.
- Output register on posedge:
  - es_allowin=0: hold all outputs.
  - es_allowin=1, stall=1: insert bubble: es_valid=0, es_we=0, es_is_load=0; other fields don't-care (drive 0).
  - es_allowin=1, stall=0: es_valid=id_valid; es_we=id_we&id_valid; copy pc, waddr, is_load, resolved src1/src2.

## Timing
- Reset (async, immediate): registers r1–r31 = 0; es_valid, es_we, es_is_load = 0; es_pc, es_src1, es_src2 = 0; es_waddr = 0.
- Read and forwarding combinational; one-cycle latency from accepted id bundle to es_* outputs.
- WB write and ID read to same register in same cycle: ID sees rf_wdata (bypass); file updated at edge.
- Load in EX: stall exactly one cycle with standard pipeline; next cycle load is in MEM and forwards from mem_fwd_wdata.
- Simultaneous EX and MEM match same register: EX value wins.
- rst asserted mid-stall or mid-hold: all state cleared, no partial write.

## Test plan
- Reset: assert rst mid-cycle -> es_valid=0, es_src1=0 immediately; read r5 after release -> 0.
- Write/read: rf_we=1, waddr=5, wdata=32'hDEADBEEF, id reads r5 same cycle -> es_src1=32'hDEADBEEF next edge; write to r0 = 32'h1234 -> read r0 returns 0.
- Forward priority: EX writes r3=32'h11, MEM writes r3=32'h22, WB writes r3=32'h33 -> es_src1=32'h11; drop EX -> 32'h22; drop MEM -> 32'h33.
- Load-use: EX load to r7, id reads r7 as src2 -> id_ready=0, bubble (es_valid=0) one cycle; next cycle MEM forwards 32'hCAFE -> es_src2=32'hCAFE, id_ready=1.
- Back-pressure: es_allowin=0 for 3 cycles with new id bundles -> es_* unchanged, id_ready=0; release -> latest bundle captured.
- Sentinel: id_valid=1, id_pc=32'h1bfffffc, es_allowin=1 -> es_valid=0, es_we=0.
